// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch stage and its instruction buffer.
package rv_fetch_pkg;

  localparam int XLEN = 32;
  localparam int INSN_BYTES = 4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch entries.
// Flush empties it in one cycle; push+pop on full is legal.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic                             flush_i,
  input  logic                             push_i,
  input  fetch_entry_t                     data_i,
  input  logic                             pop_i,
  output fetch_entry_t                     head_o,
  output logic                             empty_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(push_i);
      rd_q  <= rd_q + PW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited imem requests,
// response buffering and redirect flush towards decode.
module fetch_stage
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            nreset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instruction,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     used;
  logic [XLEN-1:0] last_pc_q;

  logic [XLEN-1:0] pcq_q [FIFO_DEPTH];
  logic [PW-1:0]   pcq_wr_q, pcq_rd_q;

  logic            req_fire, push, pop, empty;
  fetch_entry_t    push_e, head_e;

  // In-flight plus buffered entries never exceed the buffer size.
  assign used = {1'b0, outst_q} + {1'b0, fifo_cnt};

  assign imem_req_valid = nreset && !redirect_valid
                       && (used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_rsp_valid && (drop_q == '0)
             && !redirect_valid;
  assign pop  = !empty && out_ready;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      pc_d = pc_q + XLEN'(INSN_BYTES);
    end
  end

  always_comb begin
    outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d  = drop_q;
    if (redirect_valid) begin
      drop_d = outst_d;
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      pcq_wr_q  <= '0;
      pcq_rd_q  <= '0;
      last_pc_q <= '0;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      pcq_wr_q <= pcq_wr_q + PW'(req_fire);
      pcq_rd_q <= pcq_rd_q + PW'(imem_rsp_valid);
      if (!empty) begin
        last_pc_q <= head_e.pc;
      end
    end
  end

  // Request PCs, consumed in order by every response, dropped or not.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_q[pcq_wr_q] <= pc_q;
    end
  end

  assign push_e = '{pc: pcq_q[pcq_rd_q],
                    instruction: imem_rsp_data};

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_e),
    .pop_i   (pop),
    .head_o  (head_e),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  assign out_valid       = !empty;
  assign out_instruction = empty ? NOP_INSN : head_e.instruction;
  assign out_pc          = empty ? last_pc_q : head_e.pc;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of decode (CONTROLLER / ALU_CONTROLLER / GPREGS read).
- Holds the PC and issues in-order word reads to instruction memory over a valid/ready request channel, then buffers responses in a small FIFO.
- Presents one instruction plus its PC per cycle to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight instructions.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries, ≥2, power of two.

Ports:
- clk  in  1  clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; one per accepted request, in order, no backpressure.
- imem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  redirect PC this cycle.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes.
- out_instruction  out  32  instruction to decode.
- out_pc  out  XLEN  PC of out_instruction.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - imem_req_valid=0, out_valid=0.
  - out_instruction=NOP (32'h0000_0013), out_pc=0.
- Request issue:
  - imem_req_valid=1 iff nreset released and !redirect_valid and (outstanding+fifo_count) < FIFO_DEPTH.
  - imem_req_addr=pc.
  - On req handshake: pc<=pc+4 (wraps modulo 2^XLEN); outstanding++.
- Request stability: once asserted, valid and addr hold until accepted. The only exception is a redirect, which may withdraw the request; the memory must tolerate withdrawal.
- Response handling:
  - rsp_valid with drop>0: response discarded; drop--; outstanding--.
  - Otherwise: push {instruction, pc_of_request} into FIFO; outstanding--.
  - pc_of_request is tracked in a parallel PC queue, depth FIFO_DEPTH.
- Latency: minimum 2 cycles, request accept to out_valid (1-cycle memory + FIFO register).
- Output:
  - out_valid = FIFO not empty; out_instruction/out_pc = FIFO head.
  - Pop on out_valid && out_ready.
  - When empty, out_instruction holds NOP and out_pc holds the last value.
- Simultaneous push+pop on a full FIFO: allowed, since the credit rule guarantees a push never overflows.
- Redirect (single cycle, highest priority):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}; FIFO flushed.
  - drop <= outstanding after this cycle's request/response updates. A response arriving in the redirect cycle is itself discarded.
  - An out handshake in the redirect cycle completes from decode's view; the entry is flushed anyway.
  - imem_req_valid=0 during the redirect cycle; issue resumes the next cycle from the new PC.
- Back-to-back redirects: the latest wins; drop is recomputed each time.
- Counters are $clog2(FIFO_DEPTH+1) bits wide. Saturation is impossible by construction; the bench asserts it.
- Reset mid-operation clears everything immediately. The memory model must also be reset; late responses after reset release are protocol errors.

Decomposition:
- Package rv_fetch_pkg:
  - INSN_BYTES=4, NOP_INSN=32'h0000_0013, RESET_PC default.
  - fetch_entry_t typedef {pc, instruction}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with flush, count output, and the same clk/nreset.
- The top level holds pc, outstanding/drop counters and the issue logic.

Test Plan:
- Reset release, memory ready, 1-cycle response:
  - first imem_req_addr=0x0.
  - out_valid first high 2 cycles after the first accept.
  - out_pc sequence 0x0,0x4,0x8.
- Memory preloaded with 0x002080B3 (ADD x1,x1,x2) at 0x0 and 0x00208133 at 0x4, out_ready=1: out_instruction shows those words in order with matching out_pc.
- out_ready=0 for 6 cycles:
  - exactly FIFO_DEPTH requests accepted, then imem_req_valid=0.
  - raising out_ready drains 0x0,0x4 with no loss or duplication.
- 3-cycle memory latency, 2 requests outstanding, redirect_pc=0x100:
  - both stale responses are dropped.
  - next out_pc=0x100; no instruction from 0x8 appears.
- redirect_pc=0x103 → next imem_req_addr=0x100. Back-to-back redirects 0x200 then 0x300 → first out_pc=0x300.
- nreset pulsed low mid-stream with FIFO full → outputs at reset values immediately; after release, fetch restarts at RESET_PC.
